// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants and types for the LM/SM micro-op sequencer.
// Holds the opcode values, IR field positions and state encoding.
package lmsm_sequencer_pkg;

  localparam logic [3:0] LM_OPCODE  = 4'b0110;
  localparam logic [3:0] SM_OPCODE  = 4'b0111;
  localparam int         LIST_WIDTH = 8;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 9;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } seq_state_e;

  function automatic logic is_multi(input logic [3:0] opc);
    return (opc == LM_OPCODE) || (opc == SM_OPCODE);
  endfunction

endpackage

// File: rtl/lmsm_sequencer_prienc.sv
// Combinational priority encoder over the register list.
// Gives the lowest set index, that bit as a one-hot and an exactly-one-set flag.
module lmsm_sequencer_prienc
  import lmsm_sequencer_pkg::*;
(
  input  logic [LIST_WIDTH-1:0] list_i,
  output logic [2:0]            idx_o,
  output logic [LIST_WIDTH-1:0] lowbit_o,
  output logic                  single_o
);

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = LIST_WIDTH - 1; i >= 0; i--) begin
      if (list_i[i]) idx_o = 3'(i);
    end
  end

  assign lowbit_o = list_i & (~list_i + LIST_WIDTH'(1));
  assign single_o = (list_i != '0) && ((list_i & (list_i - LIST_WIDTH'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// Decode-stage expander for load/store multiple: one micro-op per set list bit,
// first micro-op issued combinationally in the cycle the IR is presented.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        IRValid,
  input  logic        hold,
  input  logic        flush,
  output logic        uopValid,
  output logic        uopIsLoad,
  output logic [2:0]  uopRA,
  output logic [2:0]  uopReg,
  output logic [2:0]  uopCount,
  output logic        uopLast,
  output logic        stallFetch,
  output logic        busy
);

  seq_state_e            state_q, state_d;
  logic [LIST_WIDTH-1:0] rem_mask_q, rem_mask_d;
  logic [2:0]            count_q, count_d;
  logic                  is_load_q, is_load_d;
  logic [2:0]            ra_q, ra_d;

  logic                  idle;
  logic [3:0]            opcode;
  logic [LIST_WIDTH-1:0] list;
  logic [LIST_WIDTH-1:0] lowbit;
  logic [2:0]            low_idx;
  logic                  single;
  logic                  act_load;
  logic [2:0]            act_ra;
  logic [2:0]            act_count;
  logic                  uop_v;
  logic                  unused_ir;

  assign unused_ir = IR[8];

  assign idle      = (state_q == IDLE);
  assign opcode    = IR[OPC_MSB:OPC_LSB];
  assign list      = idle ? IR[LIST_WIDTH-1:0] : rem_mask_q;
  assign act_load  = idle ? (opcode == LM_OPCODE) : is_load_q;
  assign act_ra    = idle ? IR[RA_MSB:RA_LSB] : ra_q;
  assign act_count = idle ? 3'd0 : count_q;
  assign uop_v     = !flush && (idle ? (IRValid && is_multi(opcode)) : 1'b1) && (list != '0);

  lmsm_sequencer_prienc u_prienc (
    .list_i   (list),
    .idx_o    (low_idx),
    .lowbit_o (lowbit),
    .single_o (single)
  );

  // IR may stay live while reset is held, so every output is masked by reset.
  assign uopValid   = uop_v && !reset;
  assign uopIsLoad  = act_load && !reset;
  assign uopRA      = reset ? 3'd0 : act_ra;
  assign uopReg     = reset ? 3'd0 : low_idx;
  assign uopCount   = reset ? 3'd0 : act_count;
  assign uopLast    = single && !reset;
  assign stallFetch = uopValid && !single;
  assign busy       = !idle && !reset;

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    count_d    = count_q;
    is_load_d  = is_load_q;
    ra_d       = ra_q;
    if (flush) begin
      state_d    = IDLE;
      rem_mask_d = '0;
      count_d    = '0;
    end else if (!hold) begin
      if (uop_v && !single) begin
        state_d    = SEQ;
        rem_mask_d = list & ~lowbit;
        count_d    = act_count + 3'd1;
        if (idle) begin
          is_load_d = act_load;
          ra_d      = act_ra;
        end
      end else if (uop_v) begin
        state_d    = IDLE;
        rem_mask_d = '0;
        count_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_mask_q <= '0;
      count_q    <= '0;
      is_load_q  <= 1'b0;
      ra_q       <= '0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      count_q    <= count_d;
      is_load_q  <= is_load_d;
      ra_q       <= ra_d;
    end
  end

endmodule
